mult_div_unit: RTL and testbench

- Iterative multiply/divide unit that consumes the two register-file read operands (rs, rt) and holds the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU in a fixed multi-cycle sequence.
- Raises busy so the control path stalls mfhi/mflo and further mult/div ops.
- Downstream consumer of the register file's readData1/readData2 outputs.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_sign_adjust.sv | 31 +++
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The early-termination option (MDU_EARLY_TERM_EN) is handled in mult_div_unit.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;
  localparam int MDU_ITERS  = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_adjust.sv
// Combinational sign handling: operand magnitudes at accept time and
// conditional two's-complement negation of the unsigned results in FIX.
module mdu_sign_adjust
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic                  sgn_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  input  logic                  neg_i,
  input  logic                  rneg_i,
  input  logic [2*DATA_W-1:0]   prod_i,
  input  logic [DATA_W-1:0]     quo_i,
  input  logic [DATA_W-1:0]     rem_i,
  output logic [DATA_W-1:0]     mag_a_o,
  output logic [DATA_W-1:0]     mag_b_o,
  output logic [2*DATA_W-1:0]   prod_o,
  output logic [DATA_W-1:0]     quo_o,
  output logic [DATA_W-1:0]     rem_o
);

  // abs(0x80..0) wraps to itself, which is the correct unsigned magnitude
  assign mag_a_o = (sgn_i && a_i[DATA_W-1]) ? (~a_i + 1'b1) : a_i;
  assign mag_b_o = (sgn_i && b_i[DATA_W-1]) ? (~b_i + 1'b1) : b_i;

  assign prod_o  = neg_i  ? (~prod_i + 1'b1) : prod_i;
  assign quo_o   = neg_i  ? (~quo_i  + 1'b1) : quo_i;
  assign rem_o   = rneg_i ? (~rem_i  + 1'b1) : rem_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one step per clock.
// Define MDU_EARLY_TERM_EN to let MUL finish once the remaining multiplier bits are zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              mt_hi_we,
  input  logic              mt_lo_we,
  input  logic [DATA_W-1:0] mt_data,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                div_q, div_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;
  logic                div_zero_q, div_zero_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic [DATA_W-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W:0]     rem_sh, trial;

  mdu_sign_adjust #(.DATA_W(DATA_W)) u_sign (
    .sgn_i   (op[0]),
    .a_i     (operand_a),
    .b_i     (operand_b),
    .neg_i   (neg_q),
    .rneg_i  (rneg_q),
    .prod_i  (prod_q),
    .quo_i   (quo_q),
    .rem_i   (rem_q),
    .mag_a_o (mag_a),
    .mag_b_o (mag_b),
    .prod_o  (prod_fix),
    .quo_o   (quo_fix),
    .rem_o   (rem_fix)
  );

  // Restoring division: quo_q doubles as the dividend shift register
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign trial  = rem_sh - {1'b0, dvsr_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mplier_d   = mplier_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    div_d      = div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      IDLE: begin
        if (mt_hi_we) hi_d = mt_data;
        if (mt_lo_we) lo_d = mt_data;
        if (start) begin
          mcand_d    = {{DATA_W{1'b0}}, mag_a};
          prod_d     = '0;
          mplier_d   = mag_b;
          quo_d      = mag_a;
          rem_d      = '0;
          dvsr_d     = mag_b;
          div_d      = op[1];
          neg_d      = op[0] & (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
          rneg_d     = op[0] & operand_a[DATA_W-1];
          dz_d       = op[1] & (operand_b == '0);
          div_zero_d = 1'b0;
          cnt_d      = '0;
          state_d    = op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
`ifdef MDU_EARLY_TERM_EN
        if (mplier_q[DATA_W-1:1] == '0) state_d = FIX;
`endif
      end
      DIV: begin
        rem_d = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        // A zero divisor still spends the full latency but leaves HI/LO alone
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      mplier_q   <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      mplier_q   <= mplier_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      div_q      <= div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, mt_hi_we, mt_lo_we;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, mt_data;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] hi_m, lo_m;
  logic        dz_m;

  mult_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we), .mt_data(mt_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Architectural result of one op, straight from the instruction definitions
  task automatic apply_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    dz_m = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin p = {32'h0, a} * {32'h0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      2'b01: begin q = sa * sb; p = q; hi_m = p[63:32]; lo_m = p[31:0]; end
      2'b10: begin
        if (b == 0) dz_m = 1'b1;
        else begin lo_m = a / b; hi_m = a % b; end
      end
      default: begin
        if (b == 0) dz_m = 1'b1;
        else begin q = sa / sb; r = sa % sb; p = q; lo_m = p[31:0]; p = r; hi_m = p[31:0]; end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
    int steps;
    logic [31:0] mb;
    if (!o[1]) begin
      mb = (o[0] && b[31]) ? -b : b;
      steps = 1;
      for (int i = 0; i < 32; i++) if (mb[i]) steps = i + 1;
      return steps + 1;
    end
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Starts at #1 after an edge with the unit idle (possibly a done cycle)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int mtlo_at, input int rst_at, input bit mt_same);
    int k, busy_cnt, lat, ndone;
    lat = exp_lat(o, b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    if (mt_same) begin mt_hi_we = 1'b1; mt_data = a ^ 32'h5A5A_5A5A; end
    @(posedge clk); #1;
    if (mt_same) hi_m = a ^ 32'h5A5A_5A5A;
    start = 1'b0; mt_hi_we = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
    chk("dz_clear", {63'h0, div_zero}, 64'h0);
    k = 0; busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      chk("hold_hi", {32'h0, hi}, {32'h0, hi_m});
      chk("hold_lo", {32'h0, lo}, {32'h0, lo_m});
      start = (k == poke_at);
      mt_lo_we = (k == mtlo_at);
      mt_data = 32'hCAFE_F00D;
      if (k == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; mt_lo_we = 1'b0;
        hi_m = '0; lo_m = '0; dz_m = 1'b0;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
        chk("rst_no_done", 64'(ndone), 64'h0);
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; mt_lo_we = 1'b0;
    chk("latency", 64'(k), 64'(lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(lat));
    chk("busy_at_done", {63'h0, busy}, 64'h0);
    apply_op(o, a, b);
    chk("hi", {32'h0, hi}, {32'h0, hi_m});
    chk("lo", {32'h0, lo}, {32'h0, lo_m});
    chk("div_zero", {63'h0, div_zero}, {63'h0, dz_m});
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    mt_hi_we = h; mt_lo_we = l; mt_data = d;
    @(posedge clk); #1;
    mt_hi_we = 1'b0; mt_lo_we = 1'b0;
    if (h) hi_m = d;
    if (l) lo_m = d;
    chk("mt_hi", {32'h0, hi}, {32'h0, hi_m});
    chk("mt_lo", {32'h0, lo}, {32'h0, lo_m});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    mt_hi_we = 1'b0; mt_lo_we = 1'b0; mt_data = '0;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_dz", {63'h0, div_zero}, 64'h0);
    chk("reset_hi", {32'h0, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1, 1'b0);
    chk("multu_hi_k", {32'h0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo_k", {32'h0, lo}, 64'h0000_0001);
    @(posedge clk); #1;
    chk("done_pulse", {63'h0, done}, 64'h0);

    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, -1, -1, -1, 1'b0);
    chk("mult_neg_lo_k", {32'h0, lo}, 64'hFFFF_FFEB);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, -1, -1, -1, 1'b0);
    chk("mult_min_hi_k", {32'h0, hi}, 64'h4000_0000);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1, -1, 1'b0);
    chk("div_neg_lo_k", {32'h0, lo}, 64'hFFFF_FFFD);
    run_op(2'b10, 32'd100, 32'd7, -1, -1, -1, 1'b0);
    chk("divu_lo_k", {32'h0, lo}, 64'd14);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 1'b0);
    chk("div_wrap_lo_k", {32'h0, lo}, 64'h8000_0000);

    mt_write(1'b1, 1'b0, 32'h1234_5678);
    run_op(2'b11, 32'd5, 32'd0, -1, -1, -1, 1'b0);
    chk("dz_hi_k", {32'h0, hi}, 64'h1234_5678);
    chk("dz_flag_k", {63'h0, div_zero}, 64'h1);
    run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 5, -1, -1, 1'b0);
    run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 5, -1, 10, 1'b0);
    @(posedge clk); #1;

    run_op(2'b00, 32'h0001_0001, 32'h8000_0003, -1, 3, -1, 1'b0);
    mt_write(1'b0, 1'b1, 32'hCAFE_F00D);
    run_op(2'b00, 32'd9, 32'd1, -1, -1, -1, 1'b0);
    chk("early_lo_k", {32'h0, lo}, 64'd9);
    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    run_op(2'b01, 32'hFFFF_0000, 32'h0000_0100, -1, -1, -1, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), rnd_opnd(), rnd_opnd(), -1, -1, -1, ($urandom % 4) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
